// File: rtl/dac_i2s_pkg.sv
// Shared constants and PCM conversion for the dac_i2s_tx serializer.
// Defining DAC_I2S_TX_LJUST_EN selects left-justified framing (data delay 0).
package dac_i2s_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_W     = CNT_W - 1;

`ifdef DAC_I2S_TX_LJUST_EN
  localparam int DATA_DELAY = 0;
`else
  localparam int DATA_DELAY = 1;
`endif

  typedef logic [SAMPLE_W-1:0] word_t;

  // Offset-binary 8-bit PCM to left-aligned two's complement; mute forces silence.
  function automatic word_t pcm_to_word(input logic [7:0] pcm, input logic mute);
    pcm_to_word = mute ? '0 : {~pcm[7], pcm[6:0], 8'h00};
  endfunction
endpackage

// File: rtl/dac_i2s_clkgen.sv
// Bit-clock divider: bclk toggles every BCLK_HALF clocks; rise/fall are
// one-cycle enables asserted in the cycle whose closing edge moves bclk.
module dac_i2s_clkgen
  import dac_i2s_pkg::*;
#(
  parameter int BCLK_HALF = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic bclk_o,
  output logic bclk_rise_o,
  output logic bclk_fall_o
);
  localparam int DIV_W = $clog2(BCLK_HALF);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             wrap;

  assign wrap = (div_q == DIV_W'(BCLK_HALF - 1));

  always_comb begin
    div_d  = wrap ? '0 : div_q + 1'b1;
    bclk_d = wrap ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o      = bclk_q;
  assign bclk_rise_o = wrap & ~bclk_q;
  assign bclk_fall_o = wrap &  bclk_q;
endmodule

// File: rtl/dac_i2s_tx.sv
// 8-bit PCM to I2S (or left-justified with DAC_I2S_TX_LJUST_EN) transmitter.
// One word is captured per 32-bit frame and repeated on both channels.
module dac_i2s_tx
  import dac_i2s_pkg::*;
#(
  parameter int BCLK_HALF = 20
) (
  input  logic       masterclk,
  input  logic       rst_n,
  input  logic [7:0] dac_out,
  input  logic       dac_mute,
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata,
  output logic       sample_strobe
);
  logic bclk_rise, bclk_fall;

  dac_i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
    .clk_i       (masterclk),
    .rst_ni      (rst_n),
    .bclk_o      (i2s_bclk),
    .bclk_rise_o (bclk_rise),
    .bclk_fall_o (bclk_fall)
  );

  // Every transmit update happens on falling bclk; the rise enable has no consumer here.
  logic unused_bclk_rise;
  assign unused_bclk_rise = bclk_rise;

  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  word_t            word_q, word_d;
  word_t            shreg_q, shreg_d;
  logic             sdata_q, sdata_d;
  logic             strobe_q, strobe_d;
  logic             load;

  always_comb begin
    bitcnt_d = bitcnt_q;
    word_d   = word_q;
    shreg_d  = shreg_q;
    sdata_d  = sdata_q;
    strobe_d = 1'b0;
    load     = 1'b0;
    if (bclk_fall) begin
      bitcnt_d = bitcnt_q + 1'b1;
      // Reload at the slot the delay dictates; otherwise keep shifting MSB-first,
      // which lets slot 0 carry the previous half's LSB in the delayed format.
      load = (bitcnt_d[SLOT_W-1:0] == SLOT_W'(DATA_DELAY));
      if (load) begin
        sdata_d = word_q[SAMPLE_W-1];
        shreg_d = {word_q[SAMPLE_W-2:0], 1'b0};
      end else begin
        sdata_d = shreg_q[SAMPLE_W-1];
        shreg_d = {shreg_q[SAMPLE_W-2:0], 1'b0};
      end
      if (bitcnt_d == CNT_W'(FRAME_BITS - 1)) begin
        word_d   = pcm_to_word(dac_out, dac_mute);
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q <= CNT_W'(FRAME_BITS - 1);
      word_q   <= '0;
      shreg_q  <= '0;
      sdata_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      word_q   <= word_d;
      shreg_q  <= shreg_d;
      sdata_q  <= sdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign i2s_lrclk     = bitcnt_q[CNT_W-1];
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;
endmodule

// File: tb/tb_dac_i2s_tx.sv
// Self-checking bench for dac_i2s_tx: waveform timing, data framing, mute,
// input isolation between strobes, and reset abort.
module tb_dac_i2s_tx;
  localparam int H    = 20;
  localparam int FR   = 64 * H;
  localparam int WQ_N = 64;

  logic       masterclk = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] dac_out   = 8'hAA;
  logic       dac_mute  = 1'b0;
  logic       i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe;

  int checks   = 0;
  int failures = 0;

  // Cycles since reset release, and the word each frame should carry.
  int          ncyc;
  logic [15:0] wq [WQ_N];

  dac_i2s_tx #(.BCLK_HALF(H)) dut (
    .masterclk     (masterclk),
    .rst_n         (rst_n),
    .dac_out       (dac_out),
    .dac_mute      (dac_mute),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .sample_strobe (sample_strobe)
  );

  always #5 masterclk = ~masterclk;

  function automatic logic [15:0] conv(input logic [7:0] d, input logic m);
    int v;
    v = (int'(d) - 128) * 256;
    return m ? 16'h0000 : 16'(v);
  endfunction

  // Expected sdata per slot of one frame; bit 31 is slot 0.
  function automatic logic [31:0] exp_frame(input logic [15:0] prev, input logic [15:0] cur);
    logic [31:0] f;
    int pos;
    f = '0;
    for (int s = 0; s < 32; s++) begin
      pos = s % 16;
`ifdef DAC_I2S_TX_LJUST_EN
      f[31-s] = cur[15-pos] | (prev[0] & 1'b0);
`else
      if (pos == 0) f[31-s] = (s == 0) ? prev[0] : cur[0];
      else          f[31-s] = cur[16-pos];
`endif
    end
    return f;
  endfunction

  // Frame f captures the inputs present at cycle f*FR after release.
  always @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      ncyc <= 0;
      for (int i = 0; i < WQ_N; i++) wq[i] <= 16'h0000;
    end else begin
      ncyc <= ncyc + 1;
      if ((ncyc + 1) % FR == 0 && (ncyc + 1) / FR < WQ_N)
        wq[(ncyc + 1) / FR] <= conv(dac_out, dac_mute);
    end
  end

  function automatic int nf();
    return ncyc / FR + 1;
  endfunction

  task automatic grab_frame(input int f, output logic [31:0] bits, output bit ok);
    int t, guard;
    ok   = 1'b1;
    bits = '0;
    for (int s = 0; s < 32; s++) begin
      t     = 2 * H * (32 * f + 1 + s) + H;
      guard = 0;
      while (ncyc < t && guard < 5 * FR) begin
        @(negedge masterclk);
        guard++;
      end
      if (ncyc != t) ok = 1'b0;
      bits[31-s] = i2s_sdata;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    dac_out  = 8'hAA;
    dac_mute = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge masterclk);
      checks++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe} !== 4'b0100) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=0100", i,
                 {i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int   n;
    int   first_rise = -1, first_fall = -1, last_rise = -1, last_lr = -1, last_stb = -1;
    logic pb = 1'b0, plr = 1'b1, psd = 1'b0, pst = 1'b0;
    logic e_b, e_lr, e_st;
    for (int i = 0; i < 2 * FR + 4 * H; i++) begin
      @(negedge masterclk);
      n    = ncyc;
      e_b  = ((n / H) % 2) == 1;
      e_lr = ((31 + n / (2 * H)) % 32) >= 16;
      e_st = (n > 0) && (n % FR == 0);
      checks++;
      if ({i2s_bclk, i2s_lrclk, sample_strobe} !== {e_b, e_lr, e_st}) begin
        failures++;
        $display("FAIL timing_wave n=%0d got=%b exp=%b", n,
                 {i2s_bclk, i2s_lrclk, sample_strobe}, {e_b, e_lr, e_st});
      end
      if (i2s_bclk && !pb) begin
        if (first_rise < 0) first_rise = n;
        else begin
          checks++;
          if (n - last_rise != 2 * H) begin
            failures++;
            $display("FAIL bclk_period got=%0d exp=%0d", n - last_rise, 2 * H);
          end
        end
        last_rise = n;
      end
      if (!i2s_bclk && pb && first_fall < 0) first_fall = n;
      if (i2s_lrclk !== plr) begin
        if (last_lr >= 0) begin
          checks++;
          if (n - last_lr != FR / 2) begin
            failures++;
            $display("FAIL lrclk_half_period got=%0d exp=%0d", n - last_lr, FR / 2);
          end
        end
        last_lr = n;
      end
      if (sample_strobe) begin
        if (last_stb >= 0) begin
          checks++;
          if (n - last_stb != FR) begin
            failures++;
            $display("FAIL strobe_spacing got=%0d exp=%0d", n - last_stb, FR);
          end
        end
        last_stb = n;
      end
      if (pst) begin
        checks++;
        if (sample_strobe !== 1'b0) begin
          failures++;
          $display("FAIL strobe_width n=%0d got=%b exp=0", n, sample_strobe);
        end
      end
      if (i2s_sdata !== psd || i2s_lrclk !== plr) begin
        checks++;
        if (!(pb && !i2s_bclk)) begin
          failures++;
          $display("FAIL change_off_fall n=%0d got_bclk_prev=%b got_bclk=%b exp=falling", n, pb, i2s_bclk);
        end
      end
      pb  = i2s_bclk;
      plr = i2s_lrclk;
      psd = i2s_sdata;
      pst = sample_strobe;
    end
    checks++;
    if (first_rise != H) begin
      failures++;
      $display("FAIL first_rise got=%0d exp=%0d", first_rise, H);
    end
    checks++;
    if (first_fall != 2 * H) begin
      failures++;
      $display("FAIL first_fall got=%0d exp=%0d", first_fall, 2 * H);
    end
  endtask

  task automatic test_data();
    logic [7:0]  din  [3] = '{8'hFF, 8'h80, 8'h00};
    logic [15:0] wexp [3] = '{16'h7F00, 16'h0000, 16'h8000};
    logic [31:0] bits, e;
    bit ok;
    int f;
    for (int i = 0; i < 3; i++) begin
      f        = nf();
      dac_out  = din[i];
      dac_mute = 1'b0;
      grab_frame(f, bits, ok);
      e = exp_frame(wq[f-1], wexp[i]);
      checks++;
      if (!ok || bits !== e) begin
        failures++;
        $display("FAIL data_%h ok=%0d got=%h exp=%h", din[i], ok, bits, e);
      end
    end
  endtask

  task automatic test_mute();
    logic [31:0] bits, e;
    bit ok;
    int f;
    dac_out  = 8'hFF;
    dac_mute = 1'b1;
    f = nf();
    grab_frame(f, bits, ok);
    checks++;
    if (!ok || bits !== 32'h0000_0000) begin
      failures++;
      $display("FAIL mute_frame ok=%0d got=%h exp=00000000", ok, bits);
    end
    dac_mute = 1'b0;
    f = nf();
    grab_frame(f, bits, ok);
    e = exp_frame(16'h0000, 16'h7F00);
    checks++;
    if (!ok || bits !== e) begin
      failures++;
      $display("FAIL unmute_frame ok=%0d got=%h exp=%h", ok, bits, e);
    end
  endtask

  task automatic test_input_change();
    logic [31:0] bits, e;
    logic [7:0]  a, b;
    bit ok;
    int f;
    a        = 8'($urandom);
    b        = 8'($urandom);
    f        = nf();
    dac_out  = a;
    dac_mute = 1'b0;
    fork
      grab_frame(f, bits, ok);
      begin
        while (ncyc <= f * FR) @(negedge masterclk);
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(50, 150)) @(negedge masterclk);
          dac_out  = 8'($urandom);
          dac_mute = 1'($urandom_range(0, 1));
        end
        dac_out  = b;
        dac_mute = 1'b0;
      end
    join
    e = exp_frame(wq[f-1], conv(a, 1'b0));
    checks++;
    if (!ok || bits !== e) begin
      failures++;
      $display("FAIL input_change_hold a=%h ok=%0d got=%h exp=%h", a, ok, bits, e);
    end
    grab_frame(f + 1, bits, ok);
    e = exp_frame(conv(a, 1'b0), conv(b, 1'b0));
    checks++;
    if (!ok || bits !== e) begin
      failures++;
      $display("FAIL input_change_next b=%h ok=%0d got=%h exp=%h", b, ok, bits, e);
    end
  endtask

  task automatic test_random();
    logic [31:0] bits, e;
    logic [7:0]  d;
    logic        m;
    bit ok;
    int f;
    for (int i = 0; i < 4; i++) begin
      d        = 8'($urandom);
      m        = ($urandom_range(0, 3) == 0);
      f        = nf();
      dac_out  = d;
      dac_mute = m;
      grab_frame(f, bits, ok);
      e = exp_frame(wq[f-1], conv(d, m));
      checks++;
      if (!ok || bits !== e) begin
        failures++;
        $display("FAIL random_%0d d=%h m=%b ok=%0d got=%h exp=%h", i, d, m, ok, bits, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] bits, e;
    bit ok;
    int f, guard;
    dac_out  = 8'hFF;
    dac_mute = 1'b0;
    f        = nf();
    guard    = 0;
    while (ncyc < f * FR + 700 && guard < 3 * FR) begin
      @(negedge masterclk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_async got=%b exp=0100", {i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe});
    end
    repeat (5) @(negedge masterclk);
    rst_n = 1'b1;
    grab_frame(0, bits, ok);
    checks++;
    if (!ok || bits !== 32'h0000_0000) begin
      failures++;
      $display("FAIL post_reset_zero ok=%0d got=%h exp=00000000", ok, bits);
    end
    grab_frame(1, bits, ok);
    e = exp_frame(16'h0000, 16'h7F00);
    checks++;
    if (!ok || bits !== e) begin
      failures++;
      $display("FAIL post_reset_resume ok=%0d got=%h exp=%h", ok, bits, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_data();
    test_mute();
    test_input_change();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
